pc_fetch: RTL and testbench
===========================

# pc_fetch

Program-counter and instruction-fetch front end of the monocycle core. It holds the architectural PC and issues a request/ready fetch to instruction memory. It presents the fetched word to decode, and on `advance` loads the next PC produced by the jump/branch select mux (`pcInstruction`, `select`). It is the consumer end of the next-PC path and the initiator end of the instruction-memory interface.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- `MAX_WAIT`, 15, number of request cycles without `imem_ready` tolerated before fault (legal 1..255).

- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high; one clock; reset is synchronous and active-high.
- `pcInstruction` in 32: next-PC candidate from the jump/branch select mux.
- `select` in 2: mux select driving `pcInstruction`. 01 = branch, 10 = pc4, 11 = register jump, 00 = no valid target.
- `advance` in 1: decode/execute has consumed `instr`; PC may update.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, always equal to `pc`.
- `imem_ready` in 1: memory returns `imem_rdata` this cycle.
- `imem_rdata` in 32: instruction word.
- `instr` out 32: captured instruction.
- `instr_valid` out 1: `instr` is valid for the current `pc`.
- `pc` out 32: current PC.
- `pc4` out 32: `pc + 4`, modulo 2^32.
- `fault` out 1: sticky fetch fault (misaligned target or memory timeout).

## Operation
- States: IDLE, REQ, HOLD, FAULT.
- Reset values:
  - Outputs: `pc`=RESET_PC, `pc4`=RESET_PC+4, `imem_req`=0, `instr`=0, `instr_valid`=0, `fault`=0.
  - Internal: state=IDLE, wait counter=0.
- IDLE: held for exactly one cycle after reset deasserts; then goes to REQ.
- REQ:
  - `imem_req`=1; wait counter cleared on entry.
  - `imem_ready`=1 → `instr`<=`imem_rdata`, `instr_valid`<=1, go to HOLD.
  - `imem_ready`=0 → counter increments.
  - If the MAX_WAIT-th REQ cycle also sees ready low → `fault`<=1, go to FAULT.
- HOLD:
  - `imem_req`=0 and `instr_valid`=1; `instr` and `pc` are stable.
  - `advance`=1 → compute next PC:
    - `select`=00 → next = `pc` (replay the same address).
    - otherwise → next = `pcInstruction`.
  - If next[1:0] != 00 → `fault`<=1, `instr_valid`<=0, go to FAULT; `pc` is unchanged.
  - Else `pc`<=next, `pc4`<=next+4, `instr_valid`<=0, go to REQ.
  - `advance`=0 → remain in HOLD; `pcInstruction` and `select` are ignored.
- FAULT:
  - Terminal until reset: `imem_req`=0, `instr_valid`=0, `fault`=1.
  - `pc` holds the last good value.
- `imem_ready` outside REQ is ignored; late responses after a redirect or reset are never captured.
- `pc4` wrap: `pc`=32'hFFFF_FFFC → `pc4`=32'h0000_0000.

## Timing
- `pc`, `pc4`, `instr`, `instr_valid`, `fault` and `imem_req` are all registered; `imem_addr` is a wire from `pc`.
- Best-case flow:
  - `advance` sampled in HOLD at cycle N → REQ with the new `imem_addr` at N+1.
  - `imem_ready` at N+1 → `instr_valid` at N+2.
  - Peak throughput: one instruction per 2 cycles.
- First fetch after reset:
  - `reset` low at edge E → IDLE in cycle E+1.
  - REQ in E+2; `instr_valid` no earlier than E+3.
- `reset` asserted in any state (including mid-REQ or FAULT) takes effect at the next edge and overrides all other inputs.
- `advance` asserted in IDLE/REQ/FAULT: no effect.

## Test plan
- Reset, then `imem_ready`=1 on the first REQ cycle with `imem_rdata`=32'h2008_0005:
  - `imem_addr`=0 during REQ.
  - `instr`=32'h2008_0005 and `instr_valid`=1 three cycles after reset release.
  - `pc4`=4.
- In HOLD, `select`=10, `pcInstruction`=4, `advance`=1:
  - Next cycle: `pc`=4, `pc4`=8, `instr_valid`=0, `imem_req`=1.
- Redirects from HOLD:
  - `select`=01, `pcInstruction`=32'h0000_0040 → `pc`=0x40.
  - Then `select`=11, `pcInstruction`=32'h0000_0100 → `pc`=0x100.
  - `select`=00 → `pc` unchanged and the same address is refetched.
- `imem_ready` held low, MAX_WAIT=15:
  - `imem_req` stays high for 15 cycles, then `fault`=1 and `imem_req`=0.
  - A later `imem_ready` pulse leaves `instr_valid`=0.
  - Only `reset` clears the fault.
- Misaligned target: `advance` with `select`=11, `pcInstruction`=32'h0000_0102 → `fault`=1, `pc` unchanged, no further requests.
- Boundary cases:
  - `pc`=32'hFFFF_FFFC → `pc4`=0.
  - `reset` asserted mid-REQ while `imem_ready` pulses on the same edge → `instr_valid`=0, `pc`=RESET_PC.

Source files
------------

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/ready bus between the fetch unit (master) and imem (slave).
interface pc_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch.sv
// PC register and instruction-fetch front end: fetches the word at pc, holds it for
// decode, and loads the next PC from the jump/branch mux on advance.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pcInstruction,
  input  logic [1:0]        select,
  input  logic              advance,
  pc_fetch_if.master        imem,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [31:0]       pc,
  output logic [31:0]       pc4,
  output logic              fault
);

  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_pc;
  logic [31:0]       w_pc_nxt;
  logic [31:0]       r_pc4;
  logic [31:0]       w_pc4_nxt;
  logic [31:0]       r_instr;
  logic [31:0]       w_instr_nxt;
  logic              r_instr_valid;
  logic              w_instr_valid_nxt;
  logic              r_fault;
  logic              w_fault_nxt;
  logic              r_imem_req;
  logic              w_imem_req_nxt;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              r_idle_hold;
  logic              w_idle_hold_nxt;
  logic [31:0]       w_target;

  // select 00 means the mux has no valid target, so the current address is replayed
  assign w_target = (select == 2'b00) ? r_pc : pcInstruction;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_pc4         <= RESET_PC + 32'd4;
      r_instr       <= 32'd0;
      r_instr_valid <= 1'b0;
      r_fault       <= 1'b0;
      r_imem_req    <= 1'b0;
      r_wait        <= '0;
      r_idle_hold   <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_pc4         <= w_pc4_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_fault       <= w_fault_nxt;
      r_imem_req    <= w_imem_req_nxt;
      r_wait        <= w_wait_nxt;
      r_idle_hold   <= w_idle_hold_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_pc4_nxt         = r_pc4;
    w_instr_nxt       = r_instr;
    w_instr_valid_nxt = r_instr_valid;
    w_fault_nxt       = r_fault;
    w_imem_req_nxt    = 1'b0;
    w_wait_nxt        = r_wait;
    w_idle_hold_nxt   = 1'b0;

    unique case (r_state)
      IDLE: begin
        // first post-reset edge only clears the hold flag, giving one full IDLE cycle
        if (!r_idle_hold) begin
          w_state_nxt    = REQ;
          w_imem_req_nxt = 1'b1;
          w_wait_nxt     = '0;
        end
      end

      REQ: begin
        if (imem.imem_ready) begin
          w_instr_nxt       = imem.imem_rdata;
          w_instr_valid_nxt = 1'b1;
          w_state_nxt       = HOLD;
        end else if (r_wait == WAIT_LAST) begin
          w_fault_nxt = 1'b1;
          w_state_nxt = FAULT;
        end else begin
          w_wait_nxt     = r_wait + WAIT_W'(1);
          w_imem_req_nxt = 1'b1;
        end
      end

      HOLD: begin
        if (advance) begin
          w_instr_valid_nxt = 1'b0;
          if (w_target[1:0] != 2'b00) begin
            w_fault_nxt = 1'b1;
            w_state_nxt = FAULT;
          end else begin
            w_pc_nxt       = w_target;
            w_pc4_nxt      = w_target + 32'd4;
            w_state_nxt    = REQ;
            w_imem_req_nxt = 1'b1;
            w_wait_nxt     = '0;
          end
        end
      end

      FAULT: begin
        w_instr_valid_nxt = 1'b0;
        w_fault_nxt       = 1'b1;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign imem.imem_req  = r_imem_req;
  assign imem.imem_addr = r_pc;
  assign instr          = r_instr;
  assign instr_valid    = r_instr_valid;
  assign pc             = r_pc;
  assign pc4            = r_pc4;
  assign fault          = r_fault;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch; issued fetch responses are queued and checked by a monitor
// whenever instr_valid rises, plus inline checks of PC/handshake behaviour.
module tb_pc_fetch;

  logic        clk;
  logic        reset;
  logic [31:0] pcInstruction;
  logic [1:0]  select;
  logic        advance;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        fault;

  pc_fetch_if bus ();

  pc_fetch #(.RESET_PC(32'h0000_0000), .MAX_WAIT(15)) dut (
    .clk           (clk),
    .reset         (reset),
    .pcInstruction (pcInstruction),
    .select        (select),
    .advance       (advance),
    .imem          (bus),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .pc4           (pc4),
    .fault         (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: each new instr_valid must match the oldest queued {pc, instr}
  initial begin
    logic prev_v;
    logic [63:0] e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (instr_valid === 1'b1 && prev_v !== 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_fetch: got pc %h instr %h expected none", pc, instr);
        end else begin
          e = exp_q.pop_front();
          chk("mon_pc", pc, e[63:32]);
          chk("mon_instr", instr, e[31:0]);
        end
      end
      prev_v = instr_valid;
    end
  end

  // Serve one fetch at address a with word d; waits a bounded time for the request
  task automatic fetch(input logic [31:0] a, input logic [31:0] d);
    int k;
    k = 0;
    while (bus.imem_req !== 1'b1 && k < 8) begin
      tick();
      k++;
    end
    chk("fetch_req", 32'(bus.imem_req), 32'd1);
    chk("fetch_addr", bus.imem_addr, a);
    bus.imem_ready = 1'b1;
    bus.imem_rdata = d;
    exp_q.push_back({a, d});
    tick();
    bus.imem_ready = 1'b0;
    chk("fetch_valid", 32'(instr_valid), 32'd1);
    chk("fetch_req_drop", 32'(bus.imem_req), 32'd0);
  endtask

  task automatic redirect(input logic [1:0] s, input logic [31:0] t);
    select        = s;
    pcInstruction = t;
    advance       = 1'b1;
    tick();
    advance       = 1'b0;
    pcInstruction = 32'h0000_0000;
    select        = 2'b00;
  endtask

  initial begin
    int cnt;
    reset          = 1'b1;
    pcInstruction  = 32'h0;
    select         = 2'b00;
    advance        = 1'b0;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'h0;
    repeat (3) tick();

    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", pc4, 32'h4);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);

    // First fetch: ready held high from release; ignored until REQ
    reset          = 1'b0;
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hBAD0_BAD0;
    tick();
    chk("idle_req", 32'(bus.imem_req), 32'd0);
    chk("idle_valid", 32'(instr_valid), 32'd0);
    bus.imem_ready = 1'b0;
    tick();
    chk("first_req", 32'(bus.imem_req), 32'd1);
    chk("first_addr", bus.imem_addr, 32'h0);
    fetch(32'h0, 32'h2008_0005);
    chk("first_instr", instr, 32'h2008_0005);
    chk("first_pc4", pc4, 32'h4);

    // Sequential advance via pc4 path
    redirect(2'b10, 32'h4);
    chk("seq_pc", pc, 32'h4);
    chk("seq_pc4", pc4, 32'h8);
    chk("seq_valid", 32'(instr_valid), 32'd0);
    chk("seq_req", 32'(bus.imem_req), 32'd1);
    fetch(32'h4, 32'h1111_0004);

    redirect(2'b01, 32'h40);
    chk("branch_pc", pc, 32'h40);
    fetch(32'h40, 32'h2222_0040);

    redirect(2'b11, 32'h100);
    chk("jr_pc", pc, 32'h100);
    chk("jr_pc4", pc4, 32'h104);
    fetch(32'h100, 32'h3333_0100);

    // select 00 ignores pcInstruction and replays the same address
    redirect(2'b00, 32'h200);
    chk("replay_pc", pc, 32'h100);
    fetch(32'h100, 32'h4444_0100);

    // HOLD without advance ignores mux inputs
    select        = 2'b11;
    pcInstruction = 32'h0000_0300;
    tick();
    tick();
    chk("hold_pc", pc, 32'h100);
    chk("hold_valid", 32'(instr_valid), 32'd1);
    chk("hold_instr", instr, 32'h4444_0100);

    // pc4 wrap
    redirect(2'b10, 32'hFFFF_FFFC);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc4, 32'h0);
    fetch(32'hFFFF_FFFC, 32'h5555_FFFC);

    // Reset mid-REQ with a coincident ready pulse
    redirect(2'b10, 32'h8);
    chk("midreq_req", 32'(bus.imem_req), 32'd1);
    chk("midreq_addr", bus.imem_addr, 32'h8);
    reset          = 1'b1;
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.imem_ready = 1'b0;
    chk("rstreq_valid", 32'(instr_valid), 32'd0);
    chk("rstreq_pc", pc, 32'h0);
    chk("rstreq_req", 32'(bus.imem_req), 32'd0);
    chk("rstreq_instr", instr, 32'h0);

    // Memory timeout: count request cycles until the fault appears
    reset = 1'b0;
    cnt   = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (fault === 1'b1) break;
      if (bus.imem_req === 1'b1) cnt++;
    end
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_req_cycles", 32'(cnt), 32'd15);
    chk("to_req_low", 32'(bus.imem_req), 32'd0);
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'h6666_6666;
    tick();
    tick();
    bus.imem_ready = 1'b0;
    chk("to_late_valid", 32'(instr_valid), 32'd0);
    redirect(2'b10, 32'h20);
    chk("to_sticky", 32'(fault), 32'd1);
    chk("to_pc", pc, 32'h0);
    reset = 1'b1;
    tick();
    chk("to_clear", 32'(fault), 32'd0);

    // Misaligned register jump
    reset = 1'b0;
    tick();
    tick();
    fetch(32'h0, 32'h7777_0000);
    redirect(2'b11, 32'h100);
    fetch(32'h100, 32'h8888_0100);
    redirect(2'b11, 32'h102);
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_pc", pc, 32'h100);
    chk("mis_valid", 32'(instr_valid), 32'd0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.imem_req === 1'b1) cnt++;
      tick();
    end
    chk("mis_no_req", 32'(cnt), 32'd0);

    tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
